// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported memory between the instruction-fetch requester
//   (port I, read-only) and the load/store requester (port D, read/write).
//   One access at a time, round-robin on conflict, registered response.
//
// Parameters
//   AddrWidth  address width, requesters and memory side
//   DataWidth  data width
//   Timeout    BUSY cycles allowed before the access is aborted; 0 = no watchdog
//
// Ports
//   clk_i, rst_ni                 clock (rising edge), async active-low reset
//   i_req_i, i_addr_i             port I read request / address
//   i_done_o                      port I completion pulse
//   d_req_i, d_we_i, d_addr_i,
//   d_wdata_i                     port D request / write enable / address / data
//   d_done_o                      port D completion pulse
//   rdata_o, err_o                response data and abort flag, valid with done
//   mem_req_o, mem_we_o,
//   mem_addr_o, mem_wdata_o       memory request side, all registered
//   mem_ready_i, mem_rdata_i      memory completion pulse and read data
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned Timeout   = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 i_req_i,
   input  logic [AddrWidth-1:0] i_addr_i,
   output logic                 i_done_o,
   input  logic                 d_req_i,
   input  logic                 d_we_i,
   input  logic [AddrWidth-1:0] d_addr_i,
   input  logic [DataWidth-1:0] d_wdata_i,
   output logic                 d_done_o,
   output logic [DataWidth-1:0] rdata_o,
   output logic                 err_o,
   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic [AddrWidth-1:0] mem_addr_o,
   output logic [DataWidth-1:0] mem_wdata_o,
   input  logic                 mem_ready_i,
   input  logic [DataWidth-1:0] mem_rdata_i
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   localparam int unsigned   CntW    = (Timeout > 2) ? $clog2(Timeout) : 1;
   localparam logic [CntW-1:0] CntLast = (Timeout == 0) ? '0 : CntW'(Timeout - 1);
   localparam bit            WdogEn  = (Timeout != 0);

   state_t          state;
   logic            last_d;   // 1 = port D was granted most recently
   logic            gnt_d;    // port owning the current access
   logic [CntW-1:0] wdog_cnt;

   logic grant_d;
   logic wdog_hit;

   // On conflict the port that did not win last time gets the grant.
   assign grant_d  = d_req_i & (~i_req_i | ~last_d);
   assign wdog_hit = WdogEn && (wdog_cnt == CntLast);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= IDLE;
         last_d      <= 1'b0;
         gnt_d       <= 1'b0;
         wdog_cnt    <= '0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         i_done_o    <= 1'b0;
         d_done_o    <= 1'b0;
         rdata_o     <= '0;
         err_o       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_req_i || d_req_i) begin
                  gnt_d       <= grant_d;
                  last_d      <= grant_d;
                  mem_we_o    <= grant_d & d_we_i;
                  mem_addr_o  <= grant_d ? d_addr_i : i_addr_i;
                  mem_wdata_o <= grant_d ? d_wdata_i : '0;
                  wdog_cnt    <= '0;
                  mem_req_o   <= 1'b1;
                  state       <= BUSY;
               end
            end
            BUSY: begin
               // A ready arriving on the watchdog's last cycle still counts
               // as a normal completion.
               if (mem_ready_i || wdog_hit) begin
                  rdata_o   <= (mem_ready_i && !mem_we_o) ? mem_rdata_i : '0;
                  err_o     <= ~mem_ready_i;
                  mem_req_o <= 1'b0;
                  i_done_o  <= ~gnt_d;
                  d_done_o  <= gnt_d;
                  state     <= RESP;
               end else begin
                  wdog_cnt <= wdog_cnt + 1'b1;
               end
            end
            RESP: begin
               i_done_o <= 1'b0;
               d_done_o <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed scenarios with literal expectations followed by randomized
//   traffic, all compared every cycle against an access-level model.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic        i_done_o;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic        d_done_o;
   logic [31:0] rdata_o;
   logic        err_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = '0;

   int n_checks = 0;
   int n_err = 0;

   mem_port_arbiter #(.AddrWidth(32), .DataWidth(32), .Timeout(TO)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .i_req_i(i_req), .i_addr_i(i_addr), .i_done_o(i_done_o),
      .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
      .d_done_o(d_done_o), .rdata_o(rdata_o), .err_o(err_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- access-level reference model ----------------
   // An access is "open" from grant until it completes; the response is
   // presented for exactly one cycle afterwards.
   logic        m_open, m_resp, m_is_d, m_we, m_last_d, m_err;
   logic [31:0] m_addr, m_wdata, m_rdata;
   int          m_waited;

   function automatic bit pick_d(input logic ir, input logic dr, input logic last_d);
      return dr && (!ir || !last_d);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_open <= 1'b0; m_resp <= 1'b0; m_is_d <= 1'b0; m_we <= 1'b0;
         m_last_d <= 1'b0; m_err <= 1'b0; m_addr <= '0; m_wdata <= '0;
         m_rdata <= '0; m_waited <= 0;
      end else if (m_resp) begin
         m_resp <= 1'b0;
      end else if (m_open) begin
         if (mem_ready) begin
            m_rdata <= m_we ? 32'h0 : mem_rdata;
            m_err   <= 1'b0;
            m_open  <= 1'b0;
            m_resp  <= 1'b1;
         end else if (TO != 0 && m_waited + 1 == TO) begin
            m_rdata <= 32'h0;
            m_err   <= 1'b1;
            m_open  <= 1'b0;
            m_resp  <= 1'b1;
         end else begin
            m_waited <= m_waited + 1;
         end
      end else if (i_req || d_req) begin
         m_is_d   <= pick_d(i_req, d_req, m_last_d);
         m_last_d <= pick_d(i_req, d_req, m_last_d);
         m_we     <= pick_d(i_req, d_req, m_last_d) ? d_we : 1'b0;
         m_addr   <= pick_d(i_req, d_req, m_last_d) ? d_addr : i_addr;
         m_wdata  <= pick_d(i_req, d_req, m_last_d) ? d_wdata : 32'h0;
         m_waited <= 0;
         m_open   <= 1'b1;
      end
   end

   always @(negedge clk) begin
      chk("mem_req", mem_req_o, m_open);
      chk("mem_we", mem_we_o, m_we);
      chk("mem_addr", mem_addr_o, m_addr);
      chk("mem_wdata", mem_wdata_o, m_wdata);
      chk("i_done", i_done_o, m_resp && !m_is_d);
      chk("d_done", d_done_o, m_resp && m_is_d);
      chk("rdata", rdata_o, m_rdata);
      chk("err", err_o, m_err);
   end

   // ---------------- directed helpers ----------------
   int          bn;
   bit          gi, gd, ge, fw;
   logic [31:0] grd, fa, fwd;

   // Issues one access, answers with ready on BUSY cycle rdy_at (0 = never).
   task automatic access(input bit is_d, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int rdy_at, input logic [31:0] mrd,
                         output int busy_n, output bit got_i, output bit got_d,
                         output logic [31:0] got_rd, output bit got_err,
                         output bit f_we, output logic [31:0] f_addr, output logic [31:0] f_wdata);
      bit done;
      done = 0; busy_n = 0; got_i = 0; got_d = 0; got_rd = '0; got_err = 0;
      f_we = 0; f_addr = '0; f_wdata = '0;
      if (is_d) begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata; end
      else begin i_req = 1; i_addr = addr; end
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         mem_ready = 0;
         if (i_done_o || d_done_o) begin
            got_i = i_done_o; got_d = d_done_o; got_rd = rdata_o; got_err = err_o;
            done = 1; i_req = 0; d_req = 0;
         end else if (mem_req_o) begin
            busy_n++;
            if (busy_n == 1) begin f_we = mem_we_o; f_addr = mem_addr_o; f_wdata = mem_wdata_o; end
            if (busy_n == rdy_at) begin mem_ready = 1; mem_rdata = mrd; end
         end
      end
      chk("access_completed", done, 1'b1);
   endtask

   // Both ports held high; returns grant order (1 = D) for n accesses.
   logic [7:0] gnt_seq, done_seq;
   int         n_done;
   task automatic conflict(input int n);
      gnt_seq = '0; done_seq = '0; n_done = 0;
      i_addr = 32'h0040_0100; d_addr = 32'h1001_0100; d_we = 0; d_wdata = '0;
      i_req = 1; d_req = 1;
      for (int c = 0; c < 100 && n_done < n; c++) begin
         @(negedge clk);
         mem_ready = 0;
         if (i_done_o || d_done_o) begin
            done_seq[n_done] = d_done_o;
            n_done++;
            if (n_done == n) begin i_req = 0; d_req = 0; end
         end else if (mem_req_o) begin
            gnt_seq[n_done] = (mem_addr_o == 32'h1001_0100);
            mem_ready = 1; mem_rdata = $urandom;
         end
      end
      chk("conflict_done_count", n_done, n);
   endtask

   task automatic do_reset();
      rst_n = 0; i_req = 0; d_req = 0; mem_ready = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
   endtask

   // ---------------- stimulus ----------------
   bit i_pend, d_pend;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_mem_req", mem_req_o, 0);
      chk("rst_done", {i_done_o, d_done_o}, 0);
      chk("rst_rdata", rdata_o, 0);
      chk("rst_err", err_o, 0);
      rst_n = 1;

      // single fetch
      access(0, 0, 32'h0040_0000, 0, 2, 32'h2408_0005, bn, gi, gd, grd, ge, fw, fa, fwd);
      chk("t1_we", fw, 0);
      chk("t1_addr", fa, 32'h0040_0000);
      chk("t1_i_done", {gi, gd}, 2'b10);
      chk("t1_rdata", grd, 32'h2408_0005);
      chk("t1_err", ge, 0);

      // store
      access(1, 1, 32'h1001_0000, 32'hDEAD_BEEF, 1, 32'h1234_5678, bn, gi, gd, grd, ge, fw, fa, fwd);
      chk("t2_we", fw, 1);
      chk("t2_wdata", fwd, 32'hDEAD_BEEF);
      chk("t2_d_done", {gi, gd}, 2'b01);
      chk("t2_rdata", grd, 0);
      chk("t2_busy", bn, 1);

      // round-robin from reset
      do_reset();
      conflict(4);
      chk("t3_grants", gnt_seq[3:0], 4'b0101);
      chk("t3_dones", done_seq[3:0], 4'b0101);

      // watchdog abort then normal access
      access(0, 0, 32'h0040_0008, 0, 0, 32'hFFFF_FFFF, bn, gi, gd, grd, ge, fw, fa, fwd);
      chk("t4_busy", bn, 4);
      chk("t4_err", ge, 1);
      chk("t4_rdata", grd, 0);
      access(1, 0, 32'h1001_0040, 0, 2, 32'hCAFE_F00D, bn, gi, gd, grd, ge, fw, fa, fwd);
      chk("t4b_err", ge, 0);
      chk("t4b_rdata", grd, 32'hCAFE_F00D);

      // ready on the last allowed BUSY cycle
      access(0, 0, 32'h0040_000C, 0, 4, 32'h0BAD_CAFE, bn, gi, gd, grd, ge, fw, fa, fwd);
      chk("t5_busy", bn, 4);
      chk("t5_err", ge, 0);
      chk("t5_rdata", grd, 32'h0BAD_CAFE);

      // async reset in BUSY
      d_req = 1; d_we = 0; d_addr = 32'h1001_0200;
      for (int c = 0; c < 10 && !mem_req_o; c++) @(negedge clk);
      chk("t6_in_busy", mem_req_o, 1);
      #2 rst_n = 0;
      #1;
      chk("t6_mem_req", mem_req_o, 0);
      chk("t6_done", {i_done_o, d_done_o}, 0);
      chk("t6_err", err_o, 0);
      d_req = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
      conflict(1);
      chk("t6_first_grant", gnt_seq[0], 1);

      // randomized traffic
      i_pend = 0; d_pend = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         mem_rdata = $urandom;
         if (mem_req_o) mem_ready = ($urandom_range(0, 3) == 0);
         else           mem_ready = ($urandom_range(0, 7) == 0);
         if (i_done_o) begin i_pend = 0; i_req = 0; end
         if (d_done_o) begin d_pend = 0; d_req = 0; end
         if (!i_pend && $urandom_range(0, 2) == 0) begin
            i_pend = 1; i_req = 1; i_addr = $urandom;
         end else if (i_pend && m_open && !m_is_d && $urandom_range(0, 15) == 0) begin
            i_req = 0;
         end
         if (!d_pend && $urandom_range(0, 2) == 0) begin
            d_pend = 1; d_req = 1; d_we = $urandom_range(0, 1);
            d_addr = $urandom; d_wdata = $urandom;
         end else if (d_pend && m_open && m_is_d && $urandom_range(0, 15) == 0) begin
            d_req = 0;
         end
      end
      i_req = 0; d_req = 0; mem_ready = 0;
      repeat (12) @(negedge clk);
      chk("drain_idle", mem_req_o, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
